// File: rtl/encoder32_5_stream_if.sv
// Output stream of the 32-to-5 event encoder: index plus matching one-hot word.
interface encoder32_5_stream_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_onehot;

    modport master (
        output out_valid,
        output out_idx,
        output out_onehot,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        output out_ready
    );
endinterface

// File: rtl/encoder32_5_stream.sv
// encoder32_5_stream: collects 32 request lines into a pending set and emits
// them one at a time as 5-bit indices over a valid/ready stream.
// Optional macro ENC_RR_EN selects round-robin priority; when it is undefined,
// the lowest pending index wins.
module encoder32_5_stream (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 req_in,
    input  logic                        clr_all,
    encoder32_5_stream_if.master        stream,
    output logic [31:0]                 pending,
    output logic                        overflow
);

    localparam int unsigned N  = 32;
    localparam int unsigned IW = 5;

    logic [N-1:0]  p_q;
    logic          valid_q;
    logic [IW-1:0] idx_q;
    logic          ovf_q;

    logic [IW-1:0] sel;
    logic          found;
    logic          load;
    logic [N-1:0]  sel_mask;
    logic [N-1:0]  p_next;
    logic          ovf_next;

`ifdef ENC_RR_EN
    logic [IW-1:0] last_q;
    logic [IW-1:0] base;
    logic [IW-1:0] off;
    logic [N-1:0]  rot;

    // Round-robin pick: rotate so the search starts just after the last grant.
    always_comb begin
        base  = last_q + IW'(1);
        rot   = N'({p_q, p_q} >> base);
        off   = '0;
        found = |rot;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
            end
        end
        sel = base + off;
    end
`else
    // Fixed priority pick: lowest set pending bit.
    always_comb begin
        sel   = '0;
        found = |p_q;
        for (int i = N - 1; i >= 0; i--) begin
            if (p_q[i]) begin
                sel = IW'(i);
            end
        end
    end
`endif

    // Slot load decision, next pending set and collision detection.
    always_comb begin
        load     = 1'b0;
        sel_mask = '0;
        p_next   = p_q;
        ovf_next = 1'b0;
        load     = (~valid_q | stream.out_ready) & found;
        if (load) begin
            sel_mask = N'(1) << sel;
        end
        p_next   = (p_q & ~sel_mask) | req_in;
        ovf_next = |(req_in & p_q & ~sel_mask);
    end

    // Pending set, output slot and overflow pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q     <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clr_all) begin
            p_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            p_q   <= p_next;
            ovf_q <= ovf_next;
            if (load) begin
                valid_q <= 1'b1;
                idx_q   <= sel;
            end else if (stream.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef ENC_RR_EN
    // Last granted index; reset to 31 so the first search starts at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= IW'(N - 1);
        end else if (!clr_all && load) begin
            last_q <= sel;
        end
    end
`endif

    assign stream.out_valid  = valid_q;
    assign stream.out_idx    = idx_q;
    assign stream.out_onehot = valid_q ? (N'(1) << idx_q) : '0;
    assign pending           = p_q;
    assign overflow          = ovf_q;

endmodule
